// File: rtl/stream_credit_tx.sv
// rtl/stream_credit_tx.sv - credit-based stream transmitter with a registered output stage
// Beats are accepted only while the sender holds a credit; the receiver returns credits via credit_i.
module stream_credit_tx #(
    parameter type         T          = logic,
    parameter int unsigned NumCredits = 4,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  T                    data_i,
    output logic                valid_o,
    output T                    data_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credits_o,
    output logic                idle_o,
    output logic                overflow_o
);

    localparam logic [CntWidth-1:0] MaxCredit = CntWidth'(NumCredits);
    localparam logic [CntWidth-1:0] OneCredit = CntWidth'(1);

    logic [CntWidth-1:0] credit_q, credit_d;
    logic                valid_q;
    T                    data_q;
    logic                overflow_q, overflow_d;
    logic                handshake;

    // ready_o looks only at the registered count, so a credit returned at zero
    // opens the gate one cycle later.
    always_comb begin
        ready_o   = (credit_q != '0) && !flush_i && !rst_i;
        handshake = valid_i && ready_o;
    end

    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (handshake && !credit_i) begin
            credit_d = credit_q - OneCredit;
        end else if (credit_i && !handshake) begin
            if (credit_q == MaxCredit) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + OneCredit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q   <= MaxCredit;
            valid_q    <= 1'b0;
            data_q     <= T'('0);
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            valid_q    <= handshake;
            overflow_q <= overflow_d;
            if (handshake) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign credits_o  = credit_q;
    assign overflow_o = overflow_q;
    assign idle_o     = (credit_q == MaxCredit) && !valid_q;

`ifndef COMMON_CELLS_ASSERTS_OFF
    // Offering a beat while flushing is a sender bug; the beat is silently refused.
    assert property (@(posedge clk_i) disable iff (rst_i) !(valid_i && flush_i));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o) |=> (flush_i || (valid_i && $stable(data_i))));
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// tb/tb_stream_credit_tx.sv - directed vector bench for stream_credit_tx
module tb_stream_credit_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_i = 8'h00;
    logic       valid_o;
    logic [7:0] data_o;
    logic       credit_i = 1'b0;
    logic [2:0] credits_o;
    logic       idle_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    stream_credit_tx #(
        .T          (logic [7:0]),
        .NumCredits (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .credit_i   (credit_i),
        .credits_o  (credits_o),
        .idle_o     (idle_o),
        .overflow_o (overflow_o)
    );

    typedef struct {
        bit         rst;
        bit         flush;
        bit         valid;
        bit         credit;
        logic [7:0] din;
        bit         e_ready;
        bit         e_vout;
        logic [7:0] e_dout;
        logic [2:0] e_cred;
        bit         e_idle;
        bit         e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input bit flush, input bit valid, input bit credit,
                                input logic [7:0] din, input bit e_ready, input bit e_vout,
                                input logic [7:0] e_dout, input logic [2:0] e_cred,
                                input bit e_idle, input bit e_ovf);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.credit = credit; v.din = din;
        v.e_ready = e_ready; v.e_vout = e_vout; v.e_dout = e_dout; v.e_cred = e_cred;
        v.e_idle = e_idle; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive inputs just after a posedge, check ready_o before the next edge,
    // then check registered outputs just after that edge.
    task automatic apply(input int idx, input vec_t v);
        rst_i = v.rst; flush_i = v.flush; valid_i = v.valid; credit_i = v.credit; data_i = v.din;
        #2;
        chk($sformatf("v%0d ready_o", idx), 32'(ready_o), 32'(v.e_ready));
        @(posedge clk_i); #1;
        chk($sformatf("v%0d valid_o", idx), 32'(valid_o), 32'(v.e_vout));
        chk($sformatf("v%0d data_o", idx), 32'(data_o), 32'(v.e_dout));
        chk($sformatf("v%0d credits_o", idx), 32'(credits_o), 32'(v.e_cred));
        chk($sformatf("v%0d idle_o", idx), 32'(idle_o), 32'(v.e_idle));
        chk($sformatf("v%0d overflow_o", idx), 32'(overflow_o), 32'(v.e_ovf));
    endtask

    initial begin
        //                 rst fl  vl  cr  din    rdy vo  dout   cred idl ovf
        vecs.push_back(mk(1, 0, 1, 0, 8'hFF, 0, 0, 8'h00, 3'd4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 3'd4, 1, 0));
        // credit exhaustion
        vecs.push_back(mk(0, 0, 1, 0, 8'hA1, 1, 1, 8'hA1, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA2, 1, 1, 8'hA2, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA3, 1, 1, 8'hA3, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA4, 1, 1, 8'hA4, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 0, 8'hA4, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'hA5, 0, 0, 8'hA4, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA5, 1, 1, 8'hA5, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 8'hA5, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hA5, 3'd2, 0, 0));
        // handshake and credit together
        vecs.push_back(mk(0, 0, 1, 1, 8'hB1, 1, 1, 8'hB1, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hB1, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hB1, 3'd4, 1, 0));
        // overflow, sticky
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hB1, 3'd4, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'hB1, 3'd4, 1, 1));
        // flush after a beat; credit still counted during flush
        vecs.push_back(mk(0, 0, 1, 0, 8'hC1, 1, 1, 8'hC1, 3'd3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'hC1, 3'd3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 8'hC1, 3'd4, 1, 1));
        // reset mid-stream
        vecs.push_back(mk(0, 0, 1, 0, 8'hD1, 1, 1, 8'hD1, 3'd3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hD2, 1, 1, 8'hD2, 3'd2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hD3, 1, 1, 8'hD3, 3'd1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 3'd4, 1, 0));

        @(posedge clk_i); #1;
        foreach (vecs[i]) apply(i, vecs[i]);

        // ready_o must be independent of valid_i
        valid_i = 1'b0; #2;
        chk("hs ready_o valid0", 32'(ready_o), 32'd1);
        valid_i = 1'b1; data_i = 8'hE1; #1;
        chk("hs ready_o valid1", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        chk("hs e1 valid_o", 32'(valid_o), 32'd1);
        chk("hs e1 data_o", 32'(data_o), 32'hE1);
        chk("hs e1 credits_o", 32'(credits_o), 32'd3);

        // full-rate stream with a credit returned every cycle keeps the count steady
        credit_i = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            data_i = 8'hE0 + 8'(k);
            @(posedge clk_i); #1;
            chk($sformatf("hs e%0d valid_o", k), 32'(valid_o), 32'd1);
            chk($sformatf("hs e%0d data_o", k), 32'(data_o), 32'(8'hE0 + 8'(k)));
            chk($sformatf("hs e%0d credits_o", k), 32'(credits_o), 32'd3);
        end
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        credit_i = 1'b0;
        chk("hs end valid_o", 32'(valid_o), 32'd0);
        chk("hs end credits_o", 32'(credits_o), 32'd4);
        chk("hs end idle_o", 32'(idle_o), 32'd1);
        chk("hs end overflow_o", 32'(overflow_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_credit_tx.md
STREAM_CREDIT_TX -- requirements
Module: stream_credit_tx

Interface
REQ-001 SHALL have parameter T: type, default logic; payload type.
REQ-002 SHALL have parameter NumCredits: int unsigned, default 4; receiver buffer depth in beats, legal range 1..255.
REQ-003 SHALL have parameter CntWidth: int unsigned, default $clog2(NumCredits+1); credit counter width, derived, not overridden.
REQ-004 SHALL have port clk_i, input, 1; single clock, all logic on posedge.
REQ-005 SHALL have port rst_i, input, 1; reset, synchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1; discards the beat held in the output stage and blocks acceptance.
REQ-007 SHALL have port valid_i, input, 1; upstream beat valid.
REQ-008 SHALL have port ready_o, output, 1; upstream ready.
REQ-009 SHALL have port data_i, input, T; upstream payload.
REQ-010 SHALL have port valid_o, output, 1; downstream beat strobe, one cycle per beat, no backpressure.
REQ-011 SHALL have port data_o, output, T; downstream payload, valid when valid_o=1.
REQ-012 SHALL have port credit_i, input, 1; one-cycle pulse, receiver freed one buffer slot.
REQ-013 SHALL have port credits_o, output, CntWidth; current available credit count.
REQ-014 SHALL have port idle_o, output, 1; high when credits_o==NumCredits and valid_o==0.
REQ-015 SHALL have port overflow_o, output, 1; sticky error, credit returned beyond NumCredits.

Function
REQ-016 SHALL accept a beat (handshake) in any cycle where valid_i && ready_o.
REQ-017 SHALL drive ready_o = (credit_q != 0) && !flush_i; ready_o SHALL NOT depend on valid_i.
REQ-018 SHALL register each accepted beat: valid_o=1 and data_o=accepted data in the cycle after the handshake; 1-cycle latency.
REQ-019 SHALL drop valid_o to 0 in any cycle following a cycle without a handshake; data_o SHALL hold its last value when valid_o=0.
REQ-020 SHALL decrement credit_q by 1 on a handshake, increment it by 1 on credit_i, and leave it unchanged when both occur in the same cycle.
REQ-021 SHALL never accept a beat when credit_q==0; valid_i stays pending with no side effects until credit_i restores a credit.
REQ-022 SHALL let credit_i arriving at credit_q==0 allow a handshake in the following cycle, not the same cycle; ready_o is registered-count based.
REQ-023 SHALL saturate credit_q at NumCredits when credit_i arrives at credit_q==NumCredits with no handshake, and set overflow_o=1 in the next cycle.
REQ-024 SHALL hold overflow_o at 1 until reset.
REQ-025 SHALL, on flush_i=1, force ready_o=0 that cycle and clear valid_o in the next cycle.
REQ-026 SHALL NOT restore or modify credit_q on flush; the credit of a beat already committed to the output stage stays consumed. Credits are returned by the receiver only.
REQ-027 SHALL still count credit_i pulses during flush.
REQ-028 SHALL drive credits_o = credit_q directly from the register.
REQ-029 SHALL evaluate idle_o from registered state only.
REQ-030 SHALL treat valid_i && flush_i in the same cycle as a protocol error: no beat is accepted and an assertion fires. The assertion SHALL be guarded by COMMON_CELLS_ASSERTS_OFF.
REQ-031 SHALL assert that valid_i, once high without a handshake, stays high with data_i stable until the handshake or a flush.

Reset
REQ-032 SHALL, when rst_i=1 at a posedge, set credit_q=NumCredits, valid_o=0, data_o=T'('0) and overflow_o=0.
REQ-033 SHALL take reset over all other inputs.
REQ-034 SHALL, on reset mid-stream, discard the pending output beat and restore full credits regardless of outstanding beats.
REQ-035 SHALL drive ready_o=0 while rst_i=1.

Verification
REQ-036 SHALL cover reset: after reset release, credits_o=4, idle_o=1, valid_o=0, ready_o=1, overflow_o=0.
REQ-037 SHALL cover credit exhaustion: 5 back-to-back beats 0xA1..0xA5 with no credit_i -> 0xA1..0xA4 on valid_o in cycles 1..4, ready_o=0 after the 4th handshake, credits_o=0; one credit_i pulse -> 0xA5 accepted the next cycle and emitted the cycle after, credits_o=0.
REQ-038 SHALL cover simultaneous events: handshake plus credit_i in the same cycle at credits_o=2 -> credits_o stays 2, beat emitted.
REQ-039 SHALL cover overflow: credit_i at credits_o=4 -> credits_o stays 4, overflow_o=1 next cycle and remains 1 until rst_i.
REQ-040 SHALL cover flush: beat accepted in cycle N, flush_i=1 in cycle N+1 -> beat seen on valid_o in N+1, valid_o=0 in N+2, ready_o=0 during N+1, credits_o unchanged by the flush.
REQ-041 SHALL cover reset mid-stream: with credits_o=1 and valid_o=1, assert rst_i -> next cycle valid_o=0, credits_o=4.
